// File: rtl/div_controller.sv
// -----------------------------------------------------------------------------
// div_controller
//
// Pipeline-side control for a multi-cycle integer divider (MIPS div/divu).
// When a divide reaches Execute, the operands are captured and the front of the
// pipeline is stalled while the divider works. The returned
// {remainder, quotient} pair is held in hi_out/lo_out. A one-cycle hilo_we
// strobe then commits it to HI/LO. An exception or flush (cancel) aborts the
// operation at any point, and the result is never written.
//
// Optional feature: define DIV_ZERO_BYPASS_EN to resolve a zero divisor
// locally (hi = dividend, lo = all ones) without ever starting the divider.
// With the macro undefined, a zero divisor goes to the divider like any other
// value.
// -----------------------------------------------------------------------------
module div_controller (
    input  logic        clka,
    input  logic        rst,
    input  logic        div_reqE,
    input  logic        signedE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        cancel,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        stall_div,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // waiting for a divide in Execute
        S_BUSY = 2'd1,   // divider running, pipeline frozen
        S_DONE = 2'd2    // result held, HI/LO write this cycle
    } state_t;

    state_t state;
    state_t state_next;

    // Load enables produced by the control logic and consumed by the
    // datapath registers below.
    logic load_ops;      // capture operands at the start of a divide
    logic load_res;      // capture divider result
    logic load_byp;      // capture locally resolved divide-by-zero result
    logic zero_divisor;  // request qualifies for the local zero bypass

    // Decide whether a zero divisor is resolved locally or sent to the divider.
`ifdef DIV_ZERO_BYPASS_EN
    assign zero_divisor = (srcbE == 32'd0);
`else
    assign zero_divisor = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; combinational blocks use blocking (=) assignments.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake and stall decode.
    always_comb begin
        // NOTE: every output of this block gets a default first. A path that
        // leaves one unassigned would infer a latch.
        state_next = state;
        div_start  = 1'b0;
        div_annul  = 1'b0;
        stall_div  = 1'b0;
        hilo_we    = 1'b0;
        load_ops   = 1'b0;
        load_res   = 1'b0;
        load_byp   = 1'b0;

        case (state)
            S_IDLE: begin
                // div_ready is deliberately ignored here: a stale ready from
                // an aborted operation must not produce a write.
                if (div_reqE) begin
                    if (cancel) begin
                        // Flushed before it ever started: tell the divider to
                        // drop anything it may have seen, and stay idle.
                        div_annul = 1'b1;
                    end else if (zero_divisor) begin
                        stall_div  = 1'b1;
                        load_byp   = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        stall_div  = 1'b1;
                        load_ops   = 1'b1;
                        state_next = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                if (cancel) begin
                    // Cancel wins even when div_ready arrives in this cycle;
                    // the result is discarded and the pipeline released.
                    div_annul  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    div_start = 1'b1;
                    stall_div = 1'b1;
                    if (div_ready) begin
                        load_res   = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // The divide instruction is still in Execute this cycle.
                // Ignore its div_reqE so it cannot restart; the pipeline
                // advances on this edge.
                hilo_we    = !cancel;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // While reset is asserted, the combinational outputs must read zero
        // too, even when div_reqE is high in the idle state.
        if (!rst) begin
            state_next = S_IDLE;
            div_start  = 1'b0;
            div_annul  = 1'b0;
            stall_div  = 1'b0;
            hilo_we    = 1'b0;
            load_ops   = 1'b0;
            load_res   = 1'b0;
            load_byp   = 1'b0;
        end
    end

    // Operand registers: loaded only when a divide is accepted. They stay
    // constant for the whole busy period, whatever forwarding does to
    // srcaE/srcbE.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            div_signed <= 1'b0;
            div_opa    <= 32'd0;
            div_opb    <= 32'd0;
        end else if (load_ops) begin
            div_signed <= signedE;
            div_opa    <= srcaE;
            div_opb    <= srcbE;
        end
    end

    // Result registers: hold the last captured value until the next capture.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            hi_out <= 32'd0;
            lo_out <= 32'd0;
        end else if (load_res) begin
            hi_out <= div_result[63:32];
            lo_out <= div_result[31:0];
        end else if (load_byp) begin
            hi_out <= srcaE;
            lo_out <= 32'hFFFF_FFFF;
        end
    end

endmodule
